// File: rtl/reg_file_pkg.sv
// Shared definitions for the parameterised register file and its clear sequencer.
package reg_file_pkg;

   localparam int unsigned DEF_DATA_W  = 32;
   localparam int unsigned DEF_ADDR_W  = 5;
   localparam int unsigned DEF_SP_IDX  = 2;
   localparam logic [31:0] DEF_SP_INIT = 32'h1001_03FC;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

endpackage

// File: rtl/reg_file_clear_seq.sv
// Sequential clear controller: walks indices 1..NUM_REGS-1, one per cycle,
// and drives the clear write port of the register array.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no clear running; user writes allowed; clear_i starts a sweep
//   CLEAR | busy; index cnt is rewritten to its clear value this cycle
module reg_file_clear_seq
   import reg_file_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_i,
   output logic              busy_o,
   output logic              clear_done_o,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_idx
);

   localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

   clr_state_e        state;
   logic [ADDR_W-1:0] cnt;
   logic              done_q;

   // State, index counter and one-cycle done pulse; index 0 is skipped since it is hardwired to zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (clear_i) begin
                  state <= CLEAR;
                  cnt   <= ADDR_W'(1);
               end
            end
            CLEAR: begin
               if (cnt == LAST_IDX) begin
                  state  <= IDLE;
                  done_q <= 1'b1;
               end else begin
                  cnt <= cnt + ADDR_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy_o       = (state == CLEAR);
   assign clear_done_o = done_q;
   assign clr_we       = busy_o;
   assign clr_idx      = cnt;

endmodule

// File: rtl/reg_file_param.sv
// Parameterised 2-read/1-write register file with a hardwired-zero index 0,
// one register with a non-zero reset value, and a sequential clear.
// Optional macro REGFILE_BYPASS_EN forwards an accepted write to a matching
// read port in the same cycle; without it reads show the pre-write value.
module reg_file_param
   import reg_file_pkg::*;
#(
   parameter int unsigned  DATA_W  = DEF_DATA_W,
   parameter int unsigned  ADDR_W  = DEF_ADDR_W,
   parameter int unsigned  SP_IDX  = DEF_SP_IDX,
   parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(DEF_SP_INIT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reg_write_i,
   input  logic [ADDR_W-1:0] write_register_i,
   input  logic [DATA_W-1:0] write_data_i,
   input  logic [ADDR_W-1:0] read_register_1_i,
   input  logic [ADDR_W-1:0] read_register_2_i,
   output logic [DATA_W-1:0] read_data_1_o,
   output logic [DATA_W-1:0] read_data_2_o,
   input  logic              clear_i,
   output logic              busy_o,
   output logic              clear_done_o
);

   localparam int unsigned       NUM_REGS = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] SP_IDX_A = ADDR_W'(SP_IDX);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              clr_we;
   logic [ADDR_W-1:0] clr_idx;
   logic              wr_acc;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;

   reg_file_clear_seq #(
      .ADDR_W (ADDR_W)
   ) u_clear_seq (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (clear_i),
      .busy_o       (busy_o),
      .clear_done_o (clear_done_o),
      .clr_we       (clr_we),
      .clr_idx      (clr_idx)
   );

   // Writes to index 0 are dropped here so the array entry never leaves zero.
   assign wr_acc = reg_write_i && !busy_o && (write_register_i != '0);

   // Array update: reset values, then clear sweep, else accepted user write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
         end
      end else if (clr_we) begin
         regs[clr_idx] <= (clr_idx == SP_IDX_A) ? SP_INIT : '0;
      end else if (wr_acc) begin
         regs[write_register_i] <= write_data_i;
      end
   end

   // Combinational read port 1, optionally bypassing the in-flight write.
   always_comb begin
      rd1 = (read_register_1_i == '0) ? '0 : regs[read_register_1_i];
`ifdef REGFILE_BYPASS_EN
      if (wr_acc && (write_register_i == read_register_1_i)) rd1 = write_data_i;
`endif
   end

   // Combinational read port 2, optionally bypassing the in-flight write.
   always_comb begin
      rd2 = (read_register_2_i == '0) ? '0 : regs[read_register_2_i];
`ifdef REGFILE_BYPASS_EN
      if (wr_acc && (write_register_i == read_register_2_i)) rd2 = write_data_i;
`endif
   end

   assign read_data_1_o = rd1;
   assign read_data_2_o = rd2;

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: stimulus queues expected values tagged
// with the cycle they apply to; a negedge monitor pops and compares them.
module tb_reg_file_param;

   localparam logic [31:0] SP = 32'h1001_03FC;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [4:0]  rsel1, rsel2;
   logic [31:0] rd1, rd2;
   logic        clr, busy, done;

   reg_file_param dut (
      .clk               (clk),
      .reset             (reset),
      .reg_write_i       (we),
      .write_register_i  (wa),
      .write_data_i      (wd),
      .read_register_1_i (rsel1),
      .read_register_2_i (rsel2),
      .read_data_1_o     (rd1),
      .read_data_2_o     (rd2),
      .clear_i           (clr),
      .busy_o            (busy),
      .clear_done_o      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      int          kind;   // 0 rd1, 1 rd2, 2 busy, 3 done
      logic [31:0] exp;
      string       name;
   } chk_t;

   chk_t sb[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   chk_t        mon_it;
   logic [31:0] mon_act;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int kind, input logic [31:0] exp, input string name);
      chk_t c;
      c.cyc  = cyc;
      c.kind = kind;
      c.exp  = exp;
      c.name = name;
      sb.push_back(c);
   endtask

   function automatic logic [31:0] rv(input int i);
      return (i == 2) ? SP : 32'h0;
   endfunction

   // Monitor: compare every expectation scheduled for the current cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
         mon_it = sb.pop_front();
         case (mon_it.kind)
            0:       mon_act = rd1;
            1:       mon_act = rd2;
            2:       mon_act = {31'b0, busy};
            default: mon_act = {31'b0, done};
         endcase
         n_tests++;
         if (mon_act !== mon_it.exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h expected %h", mon_it.name, cyc, mon_act, mon_it.exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; we = 1'b0; wa = '0; wd = '0; rsel1 = '0; rsel2 = '0; clr = 1'b0;
      tick(); tick();
      rsel1 = 5'd2; rsel2 = 5'd3;
      push(0, SP, "rst_rd_sp"); push(1, 32'h0, "rst_rd_r3");
      push(2, 32'h0, "rst_busy"); push(3, 32'h0, "rst_done");
      tick();
      reset = 1'b1;
      tick();

      // Post-reset contents
      for (int i = 0; i < 32; i++) begin
         rsel1 = 5'(i); rsel2 = 5'(31 - i);
         push(0, rv(i), "init_rd1"); push(1, rv(31 - i), "init_rd2");
         tick();
      end

      // Write reg 5, read on both ports next cycle
      we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; rsel1 = 5'd5; rsel2 = 5'd5;
      push(0, BYP ? 32'hDEAD_BEEF : 32'h0, "wr5_same_cyc");
      tick();
      we = 1'b0;
      push(0, 32'hDEAD_BEEF, "wr5_rd1"); push(1, 32'hDEAD_BEEF, "wr5_rd2");
      tick();

      // Writes to reg 0 are discarded, never bypassed
      we = 1'b1; wa = 5'd0; wd = 32'h1234; rsel1 = 5'd0;
      push(0, 32'h0, "wr0_same_cyc");
      tick();
      we = 1'b0;
      push(0, 32'h0, "wr0_rd");
      tick();

      // Same-cycle read of reg 9 during write
      we = 1'b1; wa = 5'd9; wd = 32'hA5A5; rsel1 = 5'd9; rsel2 = 5'd5;
      push(0, BYP ? 32'hA5A5 : 32'h0, "byp_r9");
      push(1, 32'hDEAD_BEEF, "byp_other_port");
      tick();
      we = 1'b0; rsel2 = 5'd9;
      push(0, 32'hA5A5, "r9_after_rd1"); push(1, 32'hA5A5, "r9_after_rd2");
      tick();

      // Fill all registers
      for (int i = 1; i < 32; i++) begin
         we = 1'b1; wa = 5'(i); wd = 32'hFFFF_FFFF;
         tick();
      end
      we = 1'b0; rsel1 = 5'd2; rsel2 = 5'd31;
      push(0, 32'hFFFF_FFFF, "fill_r2"); push(1, 32'hFFFF_FFFF, "fill_r31");
      tick();

      // Clear sequence, with a write in the start cycle
      clr = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'h1234_5678;
      push(2, 32'h0, "clr_c0_busy");
      tick();
      clr = 1'b0; we = 1'b0;
      for (int k = 1; k < 32; k++) begin
         rsel1 = 5'(k - 1); rsel2 = 5'(k);
         push(2, 32'h1, "clr_busy"); push(3, 32'h0, "clr_done_early");
         push(0, rv(k - 1), "clr_partial_done");
         push(1, (k == 3) ? 32'h1234_5678 : 32'hFFFF_FFFF, "clr_partial_pending");
         we  = (k == 10);
         wa  = 5'd7; wd = 32'h777;
         clr = (k == 20);
         tick();
      end
      we = 1'b0; clr = 1'b0;
      push(2, 32'h0, "clr_end_busy"); push(3, 32'h1, "clr_done_pulse");
      tick();
      push(2, 32'h0, "clr_after_busy"); push(3, 32'h0, "clr_done_once");
      tick();
      for (int i = 0; i < 32; i++) begin
         rsel1 = 5'(i); rsel2 = 5'(i);
         push(0, rv(i), "clr_final_rd1"); push(1, rv(i), "clr_final_rd2");
         tick();
      end

      // Reset in the middle of a clear
      we = 1'b1; wa = 5'd4; wd = 32'h44;
      tick();
      wa = 5'd30; wd = 32'h30;
      tick();
      we = 1'b0; rsel1 = 5'd4; clr = 1'b1;
      push(0, 32'h44, "pre_abort_r4");
      tick();
      clr = 1'b0;
      for (int k = 1; k < 10; k++) begin
         push(2, 32'h1, "abort_busy_pre");
         tick();
      end
      reset = 1'b0; rsel1 = 5'd30; rsel2 = 5'd2;
      push(2, 32'h0, "abort_busy"); push(3, 32'h0, "abort_done");
      push(0, 32'h0, "abort_r30"); push(1, SP, "abort_r2");
      tick();
      push(3, 32'h0, "abort_done_hold");
      tick();
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push(2, 32'h0, "post_abort_busy"); push(3, 32'h0, "post_abort_done");
         tick();
      end
      for (int i = 0; i < 32; i++) begin
         rsel1 = 5'(i); rsel2 = 5'(31 - i);
         push(0, rv(i), "abort_final_rd1"); push(1, rv(31 - i), "abort_final_rd2");
         tick();
      end

      tick();
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register and data width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the index width; NUM_REGS = 2**ADDR_W.
REQ-003 Parameter SP_IDX, default 2, SHALL select the register index that has a non-zero reset value.
REQ-004 Parameter SP_INIT, default 32'h1001_03FC, SHALL set the reset and clear value of register SP_IDX.
REQ-005 Port clk, input, 1, SHALL be the single clock; all state is updated on its rising edge.
REQ-006 Port reset, input, 1, SHALL be an asynchronous, active-low reset.
REQ-007 Port reg_write_i, input, 1, SHALL be the write enable.
REQ-008 Port write_register_i, input, ADDR_W, SHALL be the write index.
REQ-009 Port write_data_i, input, DATA_W, SHALL be the write data.
REQ-010 Ports read_register_1_i and read_register_2_i, input, ADDR_W each, SHALL be the read indices.
REQ-011 Ports read_data_1_o and read_data_2_o, output, DATA_W each, SHALL be the read data.
REQ-012 Port clear_i, input, 1, SHALL be a single-cycle request for a sequential clear.
REQ-013 Port busy_o, output, 1, SHALL be high while a clear sequence is in progress.
REQ-014 Port clear_done_o, output, 1, SHALL pulse high for one cycle when a clear completes.

Function
REQ-015 Register 0 SHALL always read 0; writes to index 0 SHALL be discarded.
REQ-016 Reads SHALL be combinational from the stored array; both ports are independent and may address the same register.
REQ-017 A write SHALL be accepted when reg_write_i=1 and busy_o=0, and SHALL be visible in the array after the next rising edge.
REQ-018 While busy_o=1, writes SHALL be ignored and dropped; no stall or acknowledge is provided.
REQ-019 The FSM SHALL have two states, IDLE and CLEAR, and SHALL reset to IDLE.
REQ-020 IDLE -> CLEAR SHALL occur on a clock edge with clear_i=1; the clear counter loads 1 and busy_o rises in the following cycle.
REQ-021 Each cycle in CLEAR SHALL write the counter's register to its clear value (SP_INIT for SP_IDX, 0 otherwise) and increment the counter.
REQ-022 When the counter equals NUM_REGS-1, that register SHALL be cleared, the FSM SHALL return to IDLE, and clear_done_o SHALL be 1 in the next cycle; the sequence lasts NUM_REGS-1 busy cycles in total (31 at the default).
REQ-023 clear_i received while in CLEAR SHALL be ignored (no restart, no queued request).
REQ-024 clear_i and an accepted write in the same IDLE cycle: the write SHALL complete first, then the sequence SHALL clear that register as normal.
REQ-025 Reads during CLEAR SHALL return the current array contents, which are partially cleared.
REQ-026 The counter is ADDR_W bits wide and SHALL never wrap past NUM_REGS-1.

Reset
REQ-027 Assertion of reset (reset=0) SHALL immediately set every register to 0 except SP_IDX, which is set to SP_INIT.
REQ-028 Assertion of reset SHALL also set state to IDLE, counter to 0, busy_o=0 and clear_done_o=0.
REQ-029 Reset in the middle of a clear SHALL abort the sequence with no clear_done_o pulse.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN, when defined, SHALL forward write_data_i to read port N in the same cycle when all of these hold: the write is accepted, write_register_i equals read_register_N_i, and the index is non-zero.
REQ-031 When REGFILE_BYPASS_EN is undefined, a read SHALL return the pre-write stored value during the write cycle.

Structure
REQ-032 A shared package reg_file_pkg SHALL hold the FSM state typedef (IDLE, CLEAR) and the default constants for SP_IDX and SP_INIT.
REQ-033 A single sub-module, reg_file_clear_seq, SHALL contain the FSM, the counter and the busy/done logic, and SHALL drive the clear write index and enable.

Verification
REQ-034 Write 32'hDEAD_BEEF to reg 5, then read both ports at 5 -> both ports return 32'hDEAD_BEEF one cycle later.
REQ-035 Write 32'h1234 to reg 0 -> read of reg 0 returns 0.
REQ-036 Release reset -> reg 2 reads 32'h1001_03FC and all other registers read 0.
REQ-037 Fill all registers with 32'hFFFF_FFFF, then pulse clear_i -> busy_o high for 31 cycles, clear_done_o high for 1 cycle, final contents match the reset values; a write to reg 7 during busy is dropped.
REQ-038 Write reg 9 = 32'hA5A5 and read reg 9 in the same cycle -> returns 32'hA5A5 with REGFILE_BYPASS_EN defined, the old value without it.
REQ-039 Assert reset at clear cycle 10 -> busy_o=0 immediately, no clear_done_o pulse, all registers hold their reset values.
